// File: rtl/bpuf_response_reader_if.sv
// Handshake and cell-array bundle between the BPUF read-out controller, the cell array
// and the key/ID consumer.
interface bpuf_response_reader_if #(
   parameter int N_BITS = 8
);
   logic              start;
   logic [N_BITS-1:0] en_mask;
   logic [N_BITS-1:0] excite;
   logic [N_BITS-1:0] q_in;
   logic              busy;
   logic              valid;
   logic [N_BITS-1:0] response;
   logic [N_BITS-1:0] unstable;

   modport master (
      output start, en_mask, q_in,
      input  excite, busy, valid, response, unstable
   );

   modport slave (
      input  start, en_mask, q_in,
      output excite, busy, valid, response, unstable
   );
endinterface

// File: rtl/bpuf_response_reader.sv
// BPUF read-out controller: excite/settle/sample repeated N_VOTES times, per-bit majority
// vote into a response word, with a flag for cells whose votes disagreed.
module bpuf_response_reader #(
   parameter int N_BITS        = 8,
   parameter int EXCITE_CYCLES = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter int N_VOTES       = 5
) (
   input logic                   clk,
   input logic                   rst_n,
   bpuf_response_reader_if.slave bus
);
   localparam int VOTE_W = $clog2(N_VOTES + 1);
   localparam int PH_W   = $clog2(EXCITE_CYCLES + SETTLE_CYCLES + 1);

   localparam logic [VOTE_W-1:0] HALF      = VOTE_W'(N_VOTES / 2);
   localparam logic [VOTE_W-1:0] FULL      = VOTE_W'(N_VOTES);
   localparam logic [VOTE_W-1:0] LAST_VOTE = VOTE_W'(N_VOTES - 1);
   localparam logic [PH_W-1:0]   E_LAST    = PH_W'(EXCITE_CYCLES - 1);
   localparam logic [PH_W-1:0]   S_LAST    = PH_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, EXCITE, SETTLE, SAMPLE, DONE} state_t;

   state_t                         state;
   logic [N_BITS-1:0]              mask;
   logic [N_BITS-1:0]              q_s1, q_s2;
   logic [N_BITS-1:0][VOTE_W-1:0]  ones, ones_nxt;
   logic [VOTE_W-1:0]              vote;
   logic [PH_W-1:0]                phase;
   logic [N_BITS-1:0]              excite_r, resp_r, unst_r;
   logic [N_BITS-1:0]              resp_nxt, unst_nxt;
   logic                           busy_r, valid_r;

   assign bus.excite   = excite_r;
   assign bus.busy     = busy_r;
   assign bus.valid    = valid_r;
   assign bus.response = resp_r;
   assign bus.unstable = unst_r;

   // Vote results include the sample being taken this cycle, so DONE can present
   // registered outputs the moment it is entered.
   always_comb begin
      ones_nxt = '0;
      resp_nxt = '0;
      unst_nxt = '0;
      for (int i = 0; i < N_BITS; i++) begin
         ones_nxt[i] = ones[i] + VOTE_W'(mask[i] & q_s2[i]);
         resp_nxt[i] = mask[i] & (ones_nxt[i] > HALF);
         unst_nxt[i] = mask[i] & (ones_nxt[i] != '0) & (ones_nxt[i] != FULL);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         mask     <= '0;
         q_s1     <= '0;
         q_s2     <= '0;
         ones     <= '0;
         vote     <= '0;
         phase    <= '0;
         excite_r <= '0;
         resp_r   <= '0;
         unst_r   <= '0;
         busy_r   <= 1'b0;
         valid_r  <= 1'b0;
      end else begin
         q_s1    <= bus.q_in;
         q_s2    <= q_s1;
         valid_r <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  mask     <= bus.en_mask;
                  ones     <= '0;
                  vote     <= '0;
                  phase    <= '0;
                  excite_r <= bus.en_mask;
                  busy_r   <= 1'b1;
                  state    <= EXCITE;
               end
            end
            EXCITE: begin
               if (phase == E_LAST) begin
                  phase    <= '0;
                  excite_r <= '0;
                  state    <= SETTLE;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end
            SETTLE: begin
               if (phase == S_LAST) begin
                  phase <= '0;
                  state <= SAMPLE;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end
            SAMPLE: begin
               ones <= ones_nxt;
               if (vote == LAST_VOTE) begin
                  valid_r <= 1'b1;
                  resp_r  <= resp_nxt;
                  unst_r  <= unst_nxt;
                  state   <= DONE;
               end else begin
                  vote     <= vote + VOTE_W'(1);
                  excite_r <= mask;
                  state    <= EXCITE;
               end
            end
            DONE: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bpuf_response_reader.sv
// Bench for bpuf_response_reader: behavioural BPUF array, table of read vectors, a
// valid scoreboard, and hand-written sequences for busy/DONE starts and mid-read reset.
module tb_bpuf_response_reader;
   localparam int LAT = 106;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bpuf_response_reader_if #(.N_BITS(8)) bus ();

   bpuf_response_reader dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      int         cyc;
      logic [7:0] r;
      logic [7:0] u;
   } exp_t;

   typedef struct {
      logic [7:0] mask;
      logic [7:0] q0, q1, q2, q3, q4;
      logic [7:0] r;
      logic [7:0] u;
   } vec_t;

   exp_t       sbq[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   int         n_valid = 0;
   int         ex_cnt = 0;
   logic [7:0] ex_or = '0;
   logic [7:0] qr[5];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Behavioural cells: each resolves to the next round's value when excite is released.
   logic [7:0] ex_prev = '0;
   logic       busy_prev = 1'b0;
   int         rnd = 0;
   always @(negedge clk) begin
      if (bus.busy && !busy_prev) rnd = 0;
      if (ex_prev != 0 && bus.excite == 0 && rnd < 5) begin
         bus.q_in = qr[rnd];
         rnd++;
      end
      ex_prev   = bus.excite;
      busy_prev = bus.busy;
   end

   // Output monitor / scoreboard consumer.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.excite != 0) begin
            ex_cnt++;
            ex_or |= bus.excite;
         end
         if (bus.valid) begin
            n_valid++;
            if (sbq.size() == 0) begin
               chk("unexpected_valid", 32'(cyc), 32'hFFFF_FFFF);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("valid_cycle", 32'(cyc), 32'(e.cyc));
               chk("response", 32'(bus.response), 32'(e.r));
               chk("unstable", 32'(bus.unstable), 32'(e.u));
            end
         end
      end
   end

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic pulse_start(input logic [7:0] mask, output int c);
      @(negedge clk);
      bus.start   = 1'b1;
      bus.en_mask = mask;
      c           = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic do_read(input vec_t v, input string tag);
      int c;
      exp_t e;
      qr[0] = v.q0; qr[1] = v.q1; qr[2] = v.q2; qr[3] = v.q3; qr[4] = v.q4;
      ex_cnt = 0;
      ex_or  = '0;
      pulse_start(v.mask, c);
      e.cyc = c + LAT; e.r = v.r; e.u = v.u;
      sbq.push_back(e);
      wait_until(c + LAT + 3);
      chk({tag, "_sb_drained"}, 32'(sbq.size()), 32'd0);
      chk({tag, "_excite_bits"}, 32'(ex_or), 32'(v.mask));
      chk({tag, "_excite_cycles"}, 32'(ex_cnt), (v.mask != 0) ? 32'd20 : 32'd0);
      sbq.delete();
   endtask

   initial begin
      vec_t tbl[6];
      int   c, nv;
      exp_t e;

      bus.start   = 1'b0;
      bus.en_mask = '0;
      bus.q_in    = '0;
      for (int i = 0; i < 5; i++) qr[i] = '0;

      //            mask   q0     q1     q2     q3     q4     resp   unst
      tbl[0] = '{8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
      tbl[1] = '{8'hFF, 8'h08, 8'h00, 8'h08, 8'h08, 8'h00, 8'h08, 8'h08};
      tbl[2] = '{8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F, 8'h00};
      tbl[3] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
      tbl[4] = '{8'hFF, 8'h0F, 8'h0F, 8'hF0, 8'hF0, 8'h0F, 8'h0F, 8'hFF};
      tbl[5] = '{8'hF0, 8'h5A, 8'h5B, 8'h5A, 8'h4A, 8'h5A, 8'h50, 8'h10};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_excite", 32'(bus.excite), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_response", 32'(bus.response), 32'd0);
      chk("rst_unstable", 32'(bus.unstable), 32'd0);

      foreach (tbl[i]) do_read(tbl[i], $sformatf("vec%0d", i));

      // start while busy and during DONE are dropped; start right after DONE is taken
      qr[0] = 8'h3C; qr[1] = 8'h3C; qr[2] = 8'h3C; qr[3] = 8'h3C; qr[4] = 8'h3C;
      nv = n_valid;
      pulse_start(8'hFF, c);
      e.cyc = c + LAT; e.r = 8'h3C; e.u = 8'h00;
      sbq.push_back(e);
      wait_until(c + 50);
      chk("busy_midread", 32'(bus.busy), 32'd1);
      bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
      wait_until(c + LAT);
      chk("busy_at_done", 32'(bus.busy), 32'd1);
      bus.start = 1'b1; @(negedge clk);
      chk("busy_after_done", 32'(bus.busy), 32'd0);
      e.cyc = c + 2 * LAT + 1;
      sbq.push_back(e);
      @(negedge clk); bus.start = 1'b0;
      wait_until(c + 2 * LAT + 4);
      chk("b2b_valid_count", 32'(n_valid - nv), 32'd2);
      chk("b2b_sb_drained", 32'(sbq.size()), 32'd0);
      sbq.delete();

      // reset mid-read aborts without a valid
      nv = n_valid;
      pulse_start(8'hFF, c);
      wait_until(c + 60);
      chk("pre_rst_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_excite", 32'(bus.excite), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_valid", 32'(bus.valid), 32'd0);
      rst_n = 1'b1;
      wait_until(c + 200);
      chk("midrst_no_valid", 32'(n_valid - nv), 32'd0);
      do_read(tbl[1], "post_rst");

      chk("final_sb_empty", 32'(sbq.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
